// File: rtl/vga_scan_ctrl_if.sv
// Graphics-side link of the VGA scan controller: read coordinates out, pixel colour back.
// master = scan controller, slave = graphics renderer.
interface vga_scan_ctrl_if;
   logic [3:0] i_r;
   logic [3:0] i_g;
   logic [3:0] i_b;
   logic [9:0] o_x_read;
   logic [9:0] o_y_read;

   modport master (
      input  i_r, i_g, i_b,
      output o_x_read, o_y_read
   );

   modport slave (
      output i_r, i_g, i_b,
      input  o_x_read, o_y_read
   );
endinterface

// File: rtl/vga_scan_ctrl.sv
// VGA 640x480@60 scan generator and pixel output stage with a per-frame tick.
// Define VGA_TESTPATTERN_EN to replace visible video with 8 vertical colour bars.
module vga_scan_ctrl #(
   parameter int CLK_DIV = 4,
   parameter int H_VIS   = 640,
   parameter int H_FP    = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int V_VIS   = 480,
   parameter int V_FP    = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33
) (
   input  logic            clk,
   input  logic            rst,
   vga_scan_ctrl_if.master gfx,
   output logic            o_frame_tick,
   output logic            o_hs,
   output logic            o_vs,
   output logic [3:0]      o_vga_r,
   output logic [3:0]      o_vga_g,
   output logic [3:0]      o_vga_b
);

   localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_VIS + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VIS + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [PW-1:0] phase;
   logic [9:0]    x_q;
   logic [9:0]    y_q;
   logic          tick;
   logic          x_last;
   logic          y_last;
   logic          vis;
   logic          hs_n;
   logic          vs_n;
   logic [11:0]   pix;

   assign tick   = (phase == PW'(CLK_DIV - 1));
   assign x_last = (x_q == 10'(H_TOT - 1));
   assign y_last = (y_q == 10'(V_TOT - 1));

   assign vis  = (x_q < 10'(H_VIS)) && (y_q < 10'(V_VIS));
   assign hs_n = !((x_q >= 10'(HS_START)) && (x_q < 10'(HS_END)));
   assign vs_n = !((y_q >= 10'(VS_START)) && (y_q < 10'(VS_END)));

`ifdef VGA_TESTPATTERN_EN
   localparam int BAR_W = H_VIS / 8;

   logic [2:0] bar;
   // Graphics colour is deliberately ignored while the pattern is active.
   wire unused_gfx_rgb = ^{gfx.i_r, gfx.i_g, gfx.i_b};

   always_comb begin
      bar = 3'(x_q / 10'(BAR_W));
      pix = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
   end
`else
   always_comb begin
      pix = {gfx.i_r, gfx.i_g, gfx.i_b};
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         phase        <= '0;
         x_q          <= '0;
         y_q          <= '0;
         o_frame_tick <= 1'b0;
         o_hs         <= 1'b1;
         o_vs         <= 1'b1;
         o_vga_r      <= '0;
         o_vga_g      <= '0;
         o_vga_b      <= '0;
      end else begin
         o_frame_tick <= 1'b0;
         phase        <= tick ? '0 : phase + 1'b1;
         if (tick) begin
            // Sample stage uses the coordinates of the pixel that is ending,
            // so RGB and syncs carry the same one-pixel latency.
            {o_vga_r, o_vga_g, o_vga_b} <= vis ? pix : 12'h000;
            o_hs <= hs_n;
            o_vs <= vs_n;
            if (x_last) begin
               x_q          <= '0;
               y_q          <= y_last ? '0 : y_q + 10'd1;
               o_frame_tick <= (y_q == 10'(V_VIS - 1));
            end else begin
               x_q <= x_q + 10'd1;
            end
         end
      end
   end

   assign gfx.o_x_read = x_q;
   assign gfx.o_y_read = y_q;

endmodule
